// File: rtl/imem_fetch_ctrl_if.sv
// imem_fetch_ctrl_if
// Bundles every signal of the fetch controller apart from clk/reset:
//   - boot/host byte stream: load_start, load_count, load_valid, load_byte,
//     load_ready, load_done
//   - datapath control: start, stall, branch_taken, branch_target, halt,
//     running
//   - instruction memory port: pc_5bits, memRead, imem_we, imem_waddr,
//     imem_wdata
// The master modport is taken by the fetch controller (it owns the memory
// port). The slave modport is the view of the surrounding host/datapath.
interface imem_fetch_ctrl_if #(
  parameter int ADDR_W = 5
);
  logic              load_start;
  logic [ADDR_W:0]   load_count;
  logic              load_valid;
  logic [7:0]        load_byte;
  logic              load_ready;
  logic              load_done;

  logic              start;
  logic              stall;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              halt;
  logic              running;

  logic [ADDR_W-1:0] pc_5bits;
  logic              memRead;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;

  modport master (
    input  load_start, load_count, load_valid, load_byte,
    input  start, stall, branch_taken, branch_target, halt,
    output load_ready, load_done, running,
    output pc_5bits, memRead, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    output load_start, load_count, load_valid, load_byte,
    output start, stall, branch_taken, branch_target, halt,
    input  load_ready, load_done, running,
    input  pc_5bits, memRead, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
// Sequencer and sole owner of the 32-word instruction memory ports. It first
// assembles a program from a big-endian byte stream and writes it word by
// word, then runs fetch by driving the word PC and the memRead enable while
// honouring halt > stall > branch > increment from the datapath.
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-high, returns to IDLE
//   bus    - imem_fetch_ctrl_if.master (byte stream, datapath control and
//            instruction memory write/read port)
// Every output is a flop; the combinational processes compute next values.
module imem_fetch_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset,
  imem_fetch_ctrl_if.master bus
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              ready_q;
  logic              run_q;
  logic [23:0]       asm_q, asm_d;
  logic [1:0]        byte_q, byte_d;
  logic [CNT_W-1:0]  word_q, word_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              accept;
  logic              last_word;
  logic [31:0]       full_word;
  logic [CNT_W-1:0]  clamped_count;

  // ready_q is only ever high while in LOAD, so it doubles as the state gate.
  assign accept    = ready_q & bus.load_valid;
  assign last_word = (word_q == count_q - CNT_W'(1));
  // Only three bytes are stored; the fourth goes straight into the write data.
  assign full_word = {asm_q, bus.load_byte};
  // A count of 0 or anything past the memory size means a full-memory load.
  assign clamped_count = (bus.load_count == '0 || bus.load_count > CNT_W'(DEPTH))
                         ? CNT_W'(DEPTH) : bus.load_count;

  // State register plus all registered outputs and load counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      run_q   <= 1'b0;
      asm_q   <= '0;
      byte_q  <= '0;
      word_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      done_q  <= done_d;
      ready_q <= (state_d == LOAD);
      run_q   <= (state_d == RUN);
      asm_q   <= asm_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      count_q <= count_d;
    end
  end

  // Next-state logic; a load request beats a simultaneous start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, HALT: begin
        if (bus.load_start) state_d = LOAD;
        else if (bus.start) state_d = RUN;
      end
      LOAD: begin
        if (accept && byte_q == 2'd3 && last_word) state_d = IDLE;
      end
      RUN: begin
        if (bus.halt) state_d = HALT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values for the PC, the write port and the byte/word counters.
  always_comb begin
    pc_d    = pc_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    asm_d   = asm_q;
    byte_d  = byte_q;
    word_d  = word_q;
    count_d = count_q;
    case (state_q)
      IDLE, HALT: begin
        if (bus.load_start) begin
          count_d = clamped_count;
          word_d  = '0;
          byte_d  = '0;
        end else if (bus.start) begin
          pc_d = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          asm_d  = {asm_q[15:0], bus.load_byte};
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd3) begin
            we_d    = 1'b1;
            waddr_d = word_q[ADDR_W-1:0];
            wdata_d = full_word;
            word_d  = word_q + CNT_W'(1);
            done_d  = last_word;
          end
        end
      end
      RUN: begin
        // A branch arriving with a stall is dropped; the datapath repeats it.
        if (!bus.halt && !bus.stall) begin
          pc_d = bus.branch_taken ? bus.branch_target : pc_q + ADDR_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign bus.pc_5bits   = pc_q;
  assign bus.memRead    = run_q;
  assign bus.running    = run_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.load_ready = ready_q;
  assign bus.load_done  = done_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl
// Randomized bench for imem_fetch_ctrl. Stimulus tasks push expected memory
// writes and expected fetch addresses into queues; independent monitors on the
// falling edge pop and compare whenever the DUT strobes a write or asserts
// memRead. A bench-side memory captures the DUT writes so fetched words can be
// compared against the program the bench intended to load.
module tb_imem_fetch_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  imem_fetch_ctrl_if #(.ADDR_W(5)) bus ();

  imem_fetch_ctrl #(.ADDR_W(5), .DEPTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        done;
  } wr_t;

  wr_t         wr_q[$];
  logic [4:0]  pc_q[$];
  logic [31:0] prog[$];
  logic [31:0] model_mem [32];
  logic [31:0] tb_mem [32];
  logic [4:0]  model_pc;
  wr_t         wr_exp;
  logic [4:0]  pc_exp;
  int          checks = 0;
  int          errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive every input for one rising edge, then return just after that edge.
  task automatic applyStimulus(input bit rst, input bit ls, input logic [5:0] lc,
                               input bit lv, input logic [7:0] lb, input bit st,
                               input bit stl, input bit br, input logic [4:0] bt,
                               input bit hl);
    reset             = rst;
    bus.load_start    = ls;
    bus.load_count    = lc;
    bus.load_valid    = lv;
    bus.load_byte     = lb;
    bus.start         = st;
    bus.stall         = stl;
    bus.branch_taken  = br;
    bus.branch_target = bt;
    bus.halt          = hl;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle(input bit rst);
    applyStimulus(rst, 0, 6'd0, 0, 8'h00, 0, 0, 0, 5'd0, 0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_pc"}, 32'(bus.pc_5bits), 32'd0);
    checkOutput({tag, "_memRead"}, 32'(bus.memRead), 32'd0);
    checkOutput({tag, "_imem_we"}, 32'(bus.imem_we), 32'd0);
    checkOutput({tag, "_imem_waddr"}, 32'(bus.imem_waddr), 32'd0);
    checkOutput({tag, "_imem_wdata"}, bus.imem_wdata, 32'd0);
    checkOutput({tag, "_load_ready"}, 32'(bus.load_ready), 32'd0);
    checkOutput({tag, "_load_done"}, 32'(bus.load_done), 32'd0);
    checkOutput({tag, "_running"}, 32'(bus.running), 32'd0);
  endtask

  // Send one byte; gap_mode 0 = back-to-back, 1 = one idle cycle before each
  // byte, 2 = random 0..2 idle cycles. Idle cycles may carry a stray start.
  task automatic sendByte(input logic [7:0] b, input int gap_mode, input bit noise);
    int gaps;
    gaps = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
    for (int g = 0; g < gaps; g++)
      applyStimulus(0, 0, 6'd0, 0, 8'($urandom), noise & $urandom_range(0, 1), 0, 0, 5'd0, 0);
    applyStimulus(0, 0, 6'd0, 1, b, 0, 0, 0, 5'd0, 0);
  endtask

  // Full program load from IDLE/HALT; words come from prog[] or are random.
  task automatic loadProgram(input logic [5:0] lc, input int gap_mode, input bit noise);
    int n;
    logic [31:0] w;
    n = (lc == 0 || lc > 32) ? 32 : int'(lc);
    applyStimulus(0, 1, lc, 0, 8'h00, noise, 0, 0, 5'd0, 0);
    checkOutput("load_ready_high", 32'(bus.load_ready), 32'd1);
    for (int i = 0; i < n; i++) begin
      w = (prog.size() > 0) ? prog.pop_front() : $urandom;
      model_mem[i] = w;
      for (int b = 0; b < 4; b++) begin
        if (b == 3) wr_q.push_back('{addr: 5'(i), data: w, done: (i == n - 1)});
        sendByte(8'(w >> (24 - 8 * b)), gap_mode, noise);
      end
    end
    checkOutput("load_ready_drop", 32'(bus.load_ready), 32'd0);
  endtask

  task automatic startRun();
    model_pc = 5'd0;
    pc_q.push_back(model_pc);
    applyStimulus(0, 0, 6'd0, 0, 8'h00, 1, 0, 0, 5'd0, 0);
  endtask

  // One RUN cycle; the reference applies halt > stall > branch > increment.
  task automatic runCycle(input bit stl, input bit br, input logic [4:0] bt,
                          input bit hl, input bit ls);
    if (!hl) begin
      if (!stl) model_pc = br ? bt : 5'((int'(model_pc) + 1) % 32);
      pc_q.push_back(model_pc);
    end
    applyStimulus(0, ls, 6'd1, 0, 8'h00, 0, stl, br, bt, hl);
  endtask

  task automatic checkHalted(input string tag);
    checkOutput({tag, "_pc_held"}, 32'(bus.pc_5bits), 32'(model_pc));
    checkOutput({tag, "_memRead"}, 32'(bus.memRead), 32'd0);
    checkOutput({tag, "_running"}, 32'(bus.running), 32'd0);
  endtask

  // Bench-side instruction memory fed by the DUT write port.
  always @(posedge clk) begin
    if (bus.imem_we === 1'b1) tb_mem[bus.imem_waddr] <= bus.imem_wdata;
  end

  // Write monitor.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      if (wr_q.size() == 0) begin
        checkOutput("unexpected_write_we", 32'(bus.imem_we), 32'd0);
      end else begin
        wr_exp = wr_q.pop_front();
        checkOutput("imem_waddr", 32'(bus.imem_waddr), 32'(wr_exp.addr));
        checkOutput("imem_wdata", bus.imem_wdata, wr_exp.data);
        checkOutput("load_done", 32'(bus.load_done), 32'(wr_exp.done));
      end
    end else if (bus.load_done === 1'b1) begin
      checkOutput("stray_load_done", 32'(bus.load_done), 32'd0);
    end
  end

  // Fetch monitor.
  always @(negedge clk) begin
    if (bus.memRead === 1'b1) begin
      if (pc_q.size() == 0) begin
        checkOutput("unexpected_memRead", 32'(bus.memRead), 32'd0);
      end else begin
        pc_exp = pc_q.pop_front();
        checkOutput("pc_5bits", 32'(bus.pc_5bits), 32'(pc_exp));
        checkOutput("running", 32'(bus.running), 32'd1);
        checkOutput("fetch_word", tb_mem[bus.pc_5bits], model_mem[pc_exp]);
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      model_mem[i] = 32'd0;
      tb_mem[i]    = 32'd0;
    end
    model_pc = 5'd0;

    idleCycle(1);
    idleCycle(1);
    $display("[TB] power-on reset");
    checkResetState("por");

    // Reset held two cycles while running at pc 7.
    startRun();
    for (int i = 0; i < 7; i++) runCycle(0, 0, 5'd0, 0, 0);
    checkOutput("pc_before_reset", 32'(bus.pc_5bits), 32'd7);
    idleCycle(1);
    idleCycle(1);
    checkResetState("run_reset");

    $display("[TB] two-word load");
    prog.push_back(32'h20080005);
    prog.push_back(32'hAC640000);
    loadProgram(6'd2, 0, 0);
    startRun();
    runCycle(0, 0, 5'd0, 0, 0);
    runCycle(0, 0, 5'd0, 0, 0);
    runCycle(0, 0, 5'd0, 1, 0);
    checkHalted("two_word_halt");

    $display("[TB] gapped full load, count 0");
    loadProgram(6'd0, 1, 1);
    startRun();
    for (int i = 0; i < 32; i++) runCycle(0, 0, 5'd0, 0, $urandom_range(0, 1));

    $display("[TB] priority");
    runCycle(0, 1, 5'd4, 0, 0);
    runCycle(1, 1, 5'd12, 0, 0);
    runCycle(0, 1, 5'd12, 0, 0);
    runCycle(0, 1, 5'd20, 1, 0);
    checkHalted("prio_halt");
    idleCycle(0);
    checkHalted("prio_hold");

    $display("[TB] random loads and run");
    loadProgram(6'd40, 2, 1);
    loadProgram(6'd5, 2, 1);
    startRun();
    for (int i = 0; i < 150; i++)
      runCycle(($urandom % 4) == 0, ($urandom % 3) == 0, 5'($urandom), 0,
               $urandom_range(0, 1));
    runCycle($urandom_range(0, 1), 1, 5'($urandom), 1, 0);
    checkHalted("random_halt");

    $display("[TB] reset mid-load");
    prog.push_back($urandom);
    applyStimulus(0, 1, 6'd4, 0, 8'h00, 0, 0, 0, 5'd0, 0);
    model_mem[0] = prog[0];
    wr_q.push_back('{addr: 5'd0, data: prog[0], done: 1'b0});
    for (int b = 0; b < 4; b++) sendByte(8'(prog[0] >> (24 - 8 * b)), 0, 0);
    void'(prog.pop_front());
    sendByte(8'($urandom), 0, 0);
    sendByte(8'($urandom), 0, 0);
    idleCycle(1);
    checkResetState("midload_reset");
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 0, 6'd0, 1, 8'($urandom), 0, 0, 0, 5'd0, 0);
    loadProgram(6'd1, 0, 0);
    startRun();
    runCycle(0, 0, 5'd0, 1, 0);
    checkHalted("final_halt");

    idleCycle(0);
    idleCycle(0);
    checkOutput("writes_pending", 32'(wr_q.size()), 32'd0);
    checkOutput("fetches_pending", 32'(pc_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Sequencer and port owner for the 32-word instruction memory. It loads a program into the memory from an 8-bit byte stream, then runs fetch. During fetch it drives the 5-bit word PC and the memRead enable, and applies stall, branch and halt requests from the datapath. It sits between the boot/host interface, the datapath control and the instruction memory, which gains a synchronous write port driven only by this block.

## Interface
- ADDR_W, 5, word-address width of instruction memory
- DEPTH, 32, number of instruction words (2^ADDR_W)
- clk  in  1  system clock, all state changes on rising edge
- reset  in  1  synchronous, active-high; forces IDLE
- load_start  in  1  request program load (honoured in IDLE/HALT)
- load_count  in  6  words to load, sampled with load_start; 1..32 valid, 0 or >32 treated as 32
- load_valid  in  1  byte on load_byte is valid
- load_byte  in  8  program byte, big-endian within each word (first byte -> [31:24])
- load_ready  out  1  block accepts a byte this cycle
- load_done  out  1  one-cycle pulse when last word written
- start  in  1  begin execution at PC 0 (honoured in IDLE/HALT)
- stall  in  1  hold PC this cycle
- branch_taken  in  1  redirect PC
- branch_target  in  ADDR_W  redirect word address
- halt  in  1  stop fetch
- pc_5bits  out  ADDR_W  fetch word address to instruction memory
- memRead  out  1  instruction memory read enable (IR forced to 0 when low)
- imem_we  out  1  instruction memory write strobe
- imem_waddr  out  ADDR_W  write word address
- imem_wdata  out  32  write data
- running  out  1  high in RUN state

## Operation
- States: IDLE, LOAD, RUN, HALT. Reset -> IDLE from any state, any cycle.
- Reset values: pc_5bits=0, memRead=0, imem_we=0, imem_waddr=0, imem_wdata=0, load_ready=0, load_done=0, running=0. The byte counter and word counter reset to 0. Memory contents are not touched.
- IDLE/HALT:
  - load_start -> LOAD: latch clamped count, word index=0, byte index=0.
  - else start -> RUN with pc=0.
  - load_start and start together: load wins.
- LOAD: load_ready=1, memRead=0, start ignored.
  - Each accepted byte (load_valid & load_ready) shifts into the 32-bit assembly register, byte index+1.
  - On the 4th byte: register imem_we=1, imem_waddr=word index, imem_wdata=assembled word for exactly one cycle; byte index->0, word index+1.
  - When the 4th byte of word count-1 is accepted: state -> IDLE on the same edge, and load_done pulses together with that final imem_we.
- RUN: memRead=1, running=1; load_start ignored. Per-cycle priority is halt > stall > branch_taken > increment.
  - halt -> HALT, pc held.
  - stall -> pc held; any branch_taken in that cycle is dropped, and the datapath re-asserts it.
  - branch_taken -> pc=branch_target.
  - else pc=pc+1 modulo 32 (31 -> 0 wrap, no flag).
- HALT: memRead=0, pc holds its last value.
- Reset mid-load: the partial word is discarded, words already written stay in memory, and no load_done is pulsed.

## Timing
- All outputs are registered. pc_5bits and memRead change only on the clk edge, and IR is valid combinationally in the same cycle.
- start sampled in cycle N: cycle N+1 has state RUN, pc_5bits=0, memRead=1.
- Branch sampled in cycle N: pc_5bits=branch_target in N+1. Fetch latency from redirect is 1 cycle.
- 4th byte accepted in cycle N: imem_we high in N+1 only.
- Back-to-back streaming is 1 byte/cycle with no bubbles, so 32 words take 128 byte cycles. The last write and load_done occur in cycle 129.
- load_valid low pauses assembly with no timeout. load_ready drops in the cycle after the final byte.

## Test plan
- Reset:
  - Stimulus: assert reset 2 cycles in RUN with pc=7.
  - Required: next cycle IDLE, pc_5bits=0, memRead=0, all strobes 0.
- Load 2 words:
  - Stimulus: load_count=2, bytes 20,08,00,05,AC,64,00,00 streamed continuously.
  - Required: imem_we at addr0 with data 0x20080005, then at addr1 with data 0xAC640000; load_done coincides with the 2nd write. Read-back via RUN fetch matches.
- Gapped load / clamp:
  - Stimulus: load_count=0, load_valid toggled every other cycle.
  - Required: exactly 32 writes to addresses 0..31, in order, none duplicated.
- Run sequence:
  - Stimulus: start, free-run 33 cycles.
  - Required: pc 0,1,...,31,0; memRead=1 throughout.
- Priority:
  - Stimulus: in RUN at pc=4, assert stall+branch_taken(target 12) for one cycle, then branch_taken alone.
  - Required: pc 4,4,12. Then halt+branch -> HALT with pc=13's predecessor held (pc unchanged) and memRead=0.
- Reset mid-load:
  - Stimulus: reset after 6 bytes of a 4-word load.
  - Required: word 0 written, no second write, no load_done. A following load_start restarts at addr 0.
